// File: rtl/proc_uart_pkg.sv
// Shared types and constants for the processor output-port UART.
// Optional build macro: UART_PARITY_EN (adds an even-parity bit, 8E1).
package proc_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic TX_IDLE   = 1'b1;
  localparam logic TX_START  = 1'b0;

endpackage

// File: rtl/proc_out_fifo.sv
// Byte capture FIFO between the core output port and the UART.
// Registered full/empty/count; pointers wrap modulo DEPTH.
module proc_out_fifo
  import proc_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr, rd;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rptr_q];
  assign wr    = push && !full;
  assign rd    = pop && !empty;

  // Pointer and occupancy update; simultaneous push/pop keeps count.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr) wptr_d = wptr_q + AW'(1);
    if (rd) rptr_d = rptr_q + AW'(1);
    if (wr && !rd) cnt_d = cnt_q + CW'(1);
    else if (!wr && rd) cnt_d = cnt_q - CW'(1);
  end

  // Pointer/count registers with synchronous flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/proc_out_uart_tx.sv
// Serialises bytes written to the core output port as UART frames.
// Optional build macro: UART_PARITY_EN (even parity, 8E1 frames).
module proc_out_uart_tx
  import proc_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    out_data,
  input  logic                          out_valid,
  output logic                          out_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam logic [15:0] BAUD_TC = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  BIT_TC  = 3'(DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;
`ifdef UART_PARITY_EN
  logic        par_q, par_d;
`endif

  logic       full, empty, pop, last;
  logic [7:0] head;

  proc_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (out_valid),
    .din   (out_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign out_ready = !full;
  assign tx        = tx_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE) || !empty;
  assign last      = (baud_q == BAUD_TC);

  // Frame sequencer: tx is registered and set for the state being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    ovf_d   = ovf_q;
    pop     = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    if (out_valid && full) ovf_d = 1'b1;
    if (state_q != IDLE) baud_d = last ? '0 : baud_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          tx_d    = TX_START;
          baud_d  = '0;
          bit_d   = '0;
`ifdef UART_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      START: begin
        if (last) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (last) begin
          if (bit_q == BIT_TC) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = TX_IDLE;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (last) begin
          state_d = STOP;
          tx_d    = TX_IDLE;
        end
      end
`endif
      STOP: begin
        if (last) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            tx_d    = TX_START;
            bit_d   = '0;
`ifdef UART_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = IDLE;
            tx_d    = TX_IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = TX_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Sequencer state with synchronous reset; reset abandons a partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= TX_IDLE;
      ovf_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_proc_out_uart_tx.sv
// Randomized bench for proc_out_uart_tx against a frame-level line model.
// Honours UART_PARITY_EN the same way as the design.
module tb_proc_out_uart_tx;

  localparam int B = 4;
  localparam int D = 4;
`ifdef UART_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  proc_out_uart_tx #(
    .BAUD_DIV   (B),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference: queue of buffered bytes plus the frame on the line.
  logic [7:0]    mq[$];
  logic [FL-1:0] fr;
  int            t = -1;
  logic          mov = 1'b0;
  int            peak = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FL-1:0] frame(input logic [7:0] d);
    logic [FL-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  task automatic model_edge(input logic v, input logic [7:0] d,
                            input logic r);
    int sz;
    if (!r) begin
      mq.delete();
      t = -1;
      mov = 1'b0;
      return;
    end
    sz = mq.size();
    if (v && sz >= D) mov = 1'b1;
    if (t < 0 || t == FL * B - 1) begin
      if (sz > 0) begin
        fr = frame(mq.pop_front());
        t = 0;
      end else begin
        t = -1;
      end
    end else begin
      t++;
    end
    if (v && sz < D) mq.push_back(d);
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    logic etx;
    out_valid = v;
    out_data  = d;
    rst_n     = r;
    @(posedge clk);
    model_edge(v, d, r);
    @(negedge clk);
    etx = (t < 0) ? 1'b1 : fr[t / B];
    if (mq.size() > peak) peak = mq.size();
    chk("tx", 32'(tx), 32'(etx));
    chk("busy", 32'(busy), 32'((t >= 0) || (mq.size() > 0)));
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("ready", 32'(out_ready), 32'(mq.size() < D));
    chk("ovf", 32'(overflow), 32'(mov));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    out_valid = 1'b0;
    out_data  = '0;
    rst_n     = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
    // Single 0x55 frame.
    cyc(1'b1, 8'h55, 1'b1);
    idle(FL * B + 5);
    // Three back-to-back frames.
    peak = 0;
    cyc(1'b1, 8'h01, 1'b1);
    cyc(1'b1, 8'h02, 1'b1);
    cyc(1'b1, 8'h03, 1'b1);
    chk("peak3", 32'(peak), 32'd2);
    idle(3 * FL * B + 5);
    // Six pushes: sixth dropped, overflow sticks.
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b1);
    chk("ovf6", 32'(overflow), 32'd1);
    idle(5 * FL * B + 5);
    // Parity-relevant bytes.
    cyc(1'b1, 8'h07, 1'b1);
    idle(FL * B + 2);
    // Reset mid-frame, held 3 cycles.
    cyc(1'b1, 8'h3C, 1'b1);
    cyc(1'b1, 8'hC3, 1'b1);
    idle(10);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    // Random traffic with rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic v;
      logic r;
      v = ($urandom_range(0, 99) < 12);
      r = ($urandom_range(0, 399) != 0);
      cyc(v, 8'($urandom), r);
    end
    idle(6 * FL * B);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
